// File: rtl/alarmclock_timer_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alarmclock_pkg                                                           |
// | Timer register map, control words, sequencer states and hh:mm:ss type.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package alarmclock_pkg;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;

    localparam logic [3:0] CTRL_RUN  = 4'h7;   // START | CONT | ITO
    localparam logic [3:0] CTRL_STOP = 4'h8;

    typedef enum logic [2:0] {
        ST_INIT_PL   = 3'd0,
        ST_INIT_PH   = 3'd1,
        ST_INIT_CTRL = 3'd2,
        ST_RUN       = 3'd3,
        ST_STOP_W    = 3'd4,
        ST_CLR_TO    = 3'd5,
        ST_CLR_WAIT  = 3'd6
    } state_t;

    typedef struct packed {
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
    } hms_t;

endpackage
`default_nettype wire

// File: rtl/alarmclock_timer_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alarmclock_timer_sequencer_if                                            |
// | Write-only register bus toward the interval timer plus its interrupt.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface alarmclock_timer_sequencer_if;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        timer_irq;

    modport master (
        output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        input  timer_irq
    );

    modport slave (
        input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        output timer_irq
    );
endinterface
`default_nettype wire

// File: rtl/alarmclock_time_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alarmclock_time_counter                                                  |
// | 24-hour hh:mm:ss counter; a load overrides a tick in the same cycle.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alarmclock_time_counter
    import alarmclock_pkg::*;
(
    input  wire  clk,
    input  wire  rst,
    input  wire  i_tick,
    input  wire  i_set,
    input  hms_t i_time,
    output hms_t o_time,
    output logic o_ticked
);

    hms_t r_time;
    hms_t w_next;
    logic r_ticked;

    // Fields at or above their limit wrap to 0, so out-of-range loads recover.
    always_comb begin
        w_next = r_time;
        if (r_time.ss >= 6'd59) begin
            w_next.ss = 6'd0;
            if (r_time.mm >= 6'd59) begin
                w_next.mm = 6'd0;
                w_next.hh = (r_time.hh >= 5'd23) ? 5'd0 : r_time.hh + 5'd1;
            end else begin
                w_next.mm = r_time.mm + 6'd1;
            end
        end else begin
            w_next.ss = r_time.ss + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_time   <= '0;
            r_ticked <= 1'b0;
        end else begin
            r_ticked <= 1'b0;
            if (i_set) begin
                r_time <= i_time;
            end else if (i_tick) begin
                r_time   <= w_next;
                r_ticked <= 1'b1;
            end
        end
    end

    assign o_time   = r_time;
    assign o_ticked = r_ticked;

endmodule
`default_nettype wire

// File: rtl/alarmclock_timer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alarmclock_timer_sequencer                                               |
// | Programs and services the interval timer as a 1 Hz base; keeps time/alarm|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alarmclock_timer_sequencer
    import alarmclock_pkg::*;
#(
    parameter logic [31:0] DEFAULT_PERIOD = 32'h02FA_F07F
) (
    input  wire                          clk,
    input  wire                          reset,
    input  wire  [31:0]                  period_in,
    input  wire                          reload,
    input  wire                          set_time,
    input  wire  [16:0]                  time_in,
    input  wire  [16:0]                  alarm_time,
    input  wire                          alarm_en,
    input  wire                          alarm_ack,
    alarmclock_timer_sequencer_if.master tmr,
    output logic [16:0]                  time_out,
    output logic                         alarm,
    output logic                         busy
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_period;
    logic        r_pending;
    logic [2:0]  r_addr,  w_addr;
    logic        r_cs,    w_cs;
    logic        r_wen,   w_wen;
    logic [15:0] r_wdata, w_wdata;
    logic        r_busy;
    logic        r_alarm;
    hms_t        w_time;
    logic        w_ticked;
    logic        w_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT_PL;
        end else begin
            r_state <= w_next;
        end
    end

    // Bus values are decided from the current state and registered one cycle later.
    always_comb begin
        w_next  = r_state;
        w_addr  = 3'd0;
        w_cs    = 1'b0;
        w_wen   = 1'b1;
        w_wdata = 16'd0;
        case (r_state)
            ST_INIT_PL: begin
                w_cs = 1'b1; w_wen = 1'b0; w_addr = ADDR_PERIODL;
                w_wdata = r_period[15:0];
                w_next = ST_INIT_PH;
            end
            ST_INIT_PH: begin
                w_cs = 1'b1; w_wen = 1'b0; w_addr = ADDR_PERIODH;
                w_wdata = r_period[31:16];
                w_next = ST_INIT_CTRL;
            end
            ST_INIT_CTRL: begin
                w_cs = 1'b1; w_wen = 1'b0; w_addr = ADDR_CONTROL;
                w_wdata = {12'd0, CTRL_RUN};
                w_next = ST_RUN;
            end
            ST_RUN: begin
                if (reload || r_pending) begin
                    w_next = ST_STOP_W;
                end else if (tmr.timer_irq) begin
                    w_next = ST_CLR_TO;
                end
            end
            ST_STOP_W: begin
                w_cs = 1'b1; w_wen = 1'b0; w_addr = ADDR_CONTROL;
                w_wdata = {12'd0, CTRL_STOP};
                w_next = ST_INIT_PL;
            end
            ST_CLR_TO: begin
                w_cs = 1'b1; w_wen = 1'b0; w_addr = ADDR_STATUS;
                w_next = ST_CLR_WAIT;
            end
            ST_CLR_WAIT: w_next = ST_RUN;
            default:     w_next = ST_INIT_PL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= 3'd0;
            r_cs    <= 1'b0;
            r_wen   <= 1'b1;
            r_wdata <= 16'd0;
            r_busy  <= 1'b1;
        end else begin
            r_addr  <= w_addr;
            r_cs    <= w_cs;
            r_wen   <= w_wen;
            r_wdata <= w_wdata;
            r_busy  <= (r_state != ST_RUN);
        end
    end

    // A reload outside RUN is remembered and replayed on the next RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period  <= DEFAULT_PERIOD;
            r_pending <= 1'b0;
        end else if (reload) begin
            r_period  <= period_in;
            r_pending <= (r_state != ST_RUN);
        end else if (r_state == ST_RUN) begin
            r_pending <= 1'b0;
        end
    end

    assign w_tick = (r_state == ST_CLR_TO);

    alarmclock_time_counter u_time_counter (
        .clk      (clk),
        .rst      (reset),
        .i_tick   (w_tick),
        .i_set    (set_time),
        .i_time   (hms_t'(time_in)),
        .o_time   (w_time),
        .o_ticked (w_ticked)
    );

    // Only tick-driven changes are compared, so loads never raise the alarm.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alarm <= 1'b0;
        end else if (w_ticked && alarm_en && (w_time == hms_t'(alarm_time))) begin
            r_alarm <= 1'b1;
        end else if (alarm_ack) begin
            r_alarm <= 1'b0;
        end
    end

    assign tmr.tmr_address    = r_addr;
    assign tmr.tmr_chipselect = r_cs;
    assign tmr.tmr_write_n    = r_wen;
    assign tmr.tmr_writedata  = r_wdata;
    assign time_out           = w_time;
    assign alarm              = r_alarm;
    assign busy               = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alarmclock_timer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alarmclock_timer_sequencer                                            |
// | Directed plus randomized bench against a seconds-of-day reference model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_alarmclock_timer_sequencer;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [31:0] period_in  = 32'd0;
    logic        reload     = 1'b0;
    logic        set_time   = 1'b0;
    logic [16:0] time_in    = 17'd0;
    logic [16:0] alarm_time = 17'd0;
    logic        alarm_en   = 1'b0;
    logic        alarm_ack  = 1'b0;
    logic [16:0] time_out;
    logic        alarm;
    logic        busy;

    alarmclock_timer_sequencer_if tmr_bus ();

    alarmclock_timer_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .period_in  (period_in),
        .reload     (reload),
        .set_time   (set_time),
        .time_in    (time_in),
        .alarm_time (alarm_time),
        .alarm_en   (alarm_en),
        .alarm_ack  (alarm_ack),
        .tmr        (tmr_bus),
        .time_out   (time_out),
        .alarm      (alarm),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t wq[$];
    int  cyc      = 0;
    int  n_cmp    = 0;
    int  n_bad    = 0;
    int  idle_bad = 0;
    int  m_secs   = 0;
    bit  m_alarm  = 1'b0;

    function automatic logic [16:0] hms(input int h, input int m, input int s);
        return {h[4:0], m[5:0], s[5:0]};
    endfunction

    function automatic logic [16:0] secs2hms(input int t);
        return hms(t / 3600, (t / 60) % 60, t % 60);
    endfunction

    // Advance one clock, then log any bus write seen in the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (tmr_bus.tmr_chipselect === 1'b1) begin
            if (tmr_bus.tmr_write_n !== 1'b0) idle_bad++;
            wq.push_back('{cyc, tmr_bus.tmr_address, tmr_bus.tmr_writedata});
        end else if (tmr_bus.tmr_address !== 3'd0 || tmr_bus.tmr_writedata !== 16'd0 ||
                     tmr_bus.tmr_write_n !== 1'b1 || tmr_bus.tmr_chipselect !== 1'b0) begin
            idle_bad++;
        end
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input string tag, input int c, input logic [2:0] a, input logic [15:0] d);
        wr_t w;
        if (wq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed no write expected cycle %0d addr %0d data %h", tag, c, a, d);
        end else begin
            w = wq.pop_front();
            chk(tag, {w.c[28:0], w.a, w.d}, {c[28:0], a, d});
        end
    endtask

    task automatic expect_no_wr(input string tag);
        chk(tag, 48'(wq.size()), 48'd0);
        wq.delete();
    endtask

    task automatic run_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_set(input logic [16:0] t);
        time_in  = t;
        set_time = 1'b1;
        step();
        set_time = 1'b0;
    endtask

    // Irq held for `width` cycles from cycle k; one status write expected at k+2.
    task automatic serve(input string tag, input int width);
        int k;
        k = cyc;
        tmr_bus.timer_irq = 1'b1;
        repeat (width) step();
        tmr_bus.timer_irq = 1'b0;
        run_until(k + 5);
        expect_wr(tag, k + 2, 3'd0, 16'd0);
        expect_no_wr({tag, "_extra"});
    endtask

    task automatic do_reload(input string tag, input logic [31:0] p);
        int k;
        k = cyc;
        period_in = p;
        reload    = 1'b1;
        step();
        reload = 1'b0;
        run_until(k + 7);
        expect_wr({tag, "_stop"}, k + 2, 3'd1, 16'h0008);
        expect_wr({tag, "_pl"},   k + 3, 3'd2, p[15:0]);
        expect_wr({tag, "_ph"},   k + 4, 3'd3, p[31:16]);
        expect_wr({tag, "_ctrl"}, k + 5, 3'd1, 16'h0007);
        expect_no_wr({tag, "_extra"});
        chk({tag, "_busy"}, 48'(busy), 48'd0);
    endtask

    initial begin
        int k;
        tmr_bus.timer_irq = 1'b0;

        // Reset values
        repeat (3) step();
        chk("rst_time",  48'(time_out), 48'd0);
        chk("rst_alarm", 48'(alarm), 48'd0);
        chk("rst_busy",  48'(busy), 48'd1);
        chk("rst_bus",   {tmr_bus.tmr_chipselect, tmr_bus.tmr_write_n, tmr_bus.tmr_address, tmr_bus.tmr_writedata},
                         {1'b0, 1'b1, 3'd0, 16'd0});
        reset = 1'b0;
        cyc   = 0;
        wq.delete();

        // Post-reset programming
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 3) chk("busy_c3", 48'(busy), 48'd1);
            if (i == 4) chk("busy_c4", 48'(busy), 48'd0);
        end
        expect_wr("init_pl",   1, 3'd2, 16'hF07F);
        expect_wr("init_ph",   2, 3'd3, 16'h02FA);
        expect_wr("init_ctrl", 3, 3'd1, 16'h0007);
        expect_no_wr("init_extra");

        // Midnight rollover
        do_set(hms(23, 59, 58));
        chk("set_2359", 48'(time_out), 48'(hms(23, 59, 58)));
        serve("irq1", 1);
        chk("t_235959", 48'(time_out), 48'(hms(23, 59, 59)));
        serve("irq2", 1);
        chk("t_000000", 48'(time_out), 48'(hms(0, 0, 0)));

        // Held irq gives one service
        serve("irq_hold", 3);
        chk("t_hold", 48'(time_out), 48'(hms(0, 0, 1)));

        // Out-of-range seconds wrap on the next carry
        do_set(hms(0, 0, 62));
        serve("irq_oor", 1);
        chk("t_oor", 48'(time_out), 48'(hms(0, 1, 0)));

        // Alarm match and acknowledge
        alarm_time = hms(7, 0, 0);
        alarm_en   = 1'b1;
        do_set(hms(6, 59, 59));
        k = cyc;
        tmr_bus.timer_irq = 1'b1;
        step();
        tmr_bus.timer_irq = 1'b0;
        step();
        chk("alarm_t",      48'(time_out), 48'(hms(7, 0, 0)));
        chk("alarm_before", 48'(alarm), 48'd0);
        step();
        chk("alarm_set", 48'(alarm), 48'd1);
        run_until(k + 5);
        expect_wr("irq_alarm", k + 2, 3'd0, 16'd0);
        expect_no_wr("irq_alarm_extra");
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        chk("alarm_ack", 48'(alarm), 48'd0);

        // set_time collides with the tick
        alarm_time = hms(12, 34, 56);
        k = cyc;
        tmr_bus.timer_irq = 1'b1;
        step();
        tmr_bus.timer_irq = 1'b0;
        time_in  = hms(12, 34, 56);
        set_time = 1'b1;
        step();
        set_time = 1'b0;
        run_until(k + 5);
        expect_wr("irq_set", k + 2, 3'd0, 16'd0);
        expect_no_wr("irq_set_extra");
        chk("set_over_tick", 48'(time_out), 48'(hms(12, 34, 56)));
        chk("set_no_alarm",  48'(alarm), 48'd0);
        m_secs = 12 * 3600 + 34 * 60 + 56;

        // Reload in RUN
        do_reload("reload_ff", 32'h0000_00FF);

        // Reload during service is deferred to the next RUN entry
        k = cyc;
        tmr_bus.timer_irq = 1'b1;
        step();
        tmr_bus.timer_irq = 1'b0;
        period_in = 32'h0001_2345;
        reload    = 1'b1;
        step();
        reload = 1'b0;
        run_until(k + 10);
        expect_wr("pend_clr",  k + 2, 3'd0, 16'd0);
        expect_wr("pend_stop", k + 5, 3'd1, 16'h0008);
        expect_wr("pend_pl",   k + 6, 3'd2, 16'h2345);
        expect_wr("pend_ph",   k + 7, 3'd3, 16'h0001);
        expect_wr("pend_ctrl", k + 8, 3'd1, 16'h0007);
        expect_no_wr("pend_extra");
        m_secs = (m_secs + 1) % 86400;
        chk("pend_time", 48'(time_out), 48'(secs2hms(m_secs)));

        // Randomized mix against the seconds-of-day model
        m_alarm = 1'b0;
        for (int i = 0; i < 40; i++) begin
            int r;
            int t;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                t = $urandom_range(0, 86399);
                do_set(secs2hms(t));
                m_secs = t;
                chk("rnd_set", 48'(time_out), 48'(secs2hms(m_secs)));
            end else if (r == 2) begin
                do_reload("rnd_reload", $urandom);
            end else if (r == 3) begin
                alarm_ack = 1'b1;
                step();
                alarm_ack = 1'b0;
                m_alarm = 1'b0;
                chk("rnd_ack", 48'(alarm), 48'(m_alarm));
            end else begin
                alarm_en   = 1'($urandom_range(0, 1));
                alarm_time = ($urandom_range(0, 1) == 1) ? secs2hms((m_secs + 1) % 86400)
                                                         : secs2hms($urandom_range(0, 86399));
                serve("rnd_irq", $urandom_range(1, 3));
                m_secs = (m_secs + 1) % 86400;
                if (alarm_en && secs2hms(m_secs) == alarm_time) m_alarm = 1'b1;
                chk("rnd_time",  48'(time_out), 48'(secs2hms(m_secs)));
                chk("rnd_alarm", 48'(alarm), 48'(m_alarm));
            end
        end

        chk("bus_idle", 48'(idle_bad), 48'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
